z80_blk_xfer_unit: RTL and testbench
====================================

Name: z80_blk_xfer_unit

Overview:
Execution unit for the Z80 block-transfer group (LDI, LDD, LDIR, LDDR). It runs each iteration as a memory read at HL, a memory write at DE, then a register update. Each iteration retires as one Z80FI instruction record. It sits directly upstream of the z80fi per-instruction spec checkers, which consume its retirement record.

Parameters:
ACK_TIMEOUT, 0, cycles to wait for mem_ack before aborting; 0 = wait forever.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin operation; sampled only in IDLE
op  in  2  00=LDI, 01=LDD, 10=LDIR, 11=LDDR
ip_in  in  16  address of the ED prefix byte
bc_in / de_in / hl_in  in  16  register values at start
a_in  in  8  accumulator; used only with the optional feature
f_in  in  8  flags at start
int_req  in  1  pending interrupt; breaks the repeat loop
busy  out  1  high from the cycle after start is accepted until the return to IDLE
mem_rd  out  1  read request
mem_wr  out  1  write request
mem_addr  out  16  request address
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid with mem_ack
mem_ack  in  1  completes the current request
bc_out / de_out / hl_out / f_out / ip_out  out  16/16/16/8/16  architectural result of the latest iteration
abort  out  1  one-cycle pulse on ack timeout
z80fi_valid  out  1  one-cycle retirement pulse
z80fi_insn  out  16  {second byte, 8'hED}; second byte A0/A8/B0/B8 per op
z80fi_mem_raddr / z80fi_mem_waddr  out  16  HL / DE of the iteration
z80fi_mem_rdata / z80fi_mem_wdata  out  8  byte read / byte written (equal)
z80fi_reg_{bc,de,hl,ip}_in / _out  out  16  per-iteration before/after values
z80fi_reg_f_in / _out  out  8  per-iteration before/after flags

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state to IDLE. All outputs 0, including busy, mem_rd, mem_wr, z80fi_valid and abort; regardless of state, including mid-transfer.
- States: IDLE, READ, WRITE, RETIRE.
- IDLE: on start=1, latch op, ip, bc, de, hl, f and a; go to READ next cycle. start while busy is ignored.
- READ: mem_rd=1, mem_addr=HL. On mem_ack, latch mem_rdata and go to WRITE.
- WRITE: mem_rd=0, mem_wr=1, mem_addr=DE, mem_wdata=latched byte. On mem_ack, go to RETIRE.
- A request completes only in a cycle where the request is high and mem_ack=1. mem_ack in any other cycle is ignored.
- RETIRE (exactly 1 cycle):
  - z80fi_valid=1 for this cycle only.
  - BC'=BC-1 mod 2^16.
  - Increment ops (LDI/LDIR): HL'=HL+1, DE'=DE+1. Decrement ops (LDD/LDDR): HL'=HL-1, DE'=DE-1. All wrap mod 2^16.
  - F' = F with H=0, N=0, PV=(BC'!=0); S, Z and C preserved.
  - IP' = ip+2, except a repeat op with BC'!=0 gives IP'=ip (re-execute).
  - Architectural outputs and z80fi_*_out take the primed values; z80fi_*_in take the values at the start of the iteration.
- After RETIRE:
  - Repeat op with BC'!=0 and int_req=0: go to READ using the primed registers. There is no dead cycle.
  - Otherwise: go to IDLE; busy falls.
  - int_req is sampled only in RETIRE. IP'=ip still holds, so re-execution resumes after the interrupt.
- BC=0 on entry: decrements to FFFF with PV=1; LDIR/LDDR therefore run 65536 iterations.
- Timeout:
  - With ACK_TIMEOUT>0, a counter runs while in READ or WRITE and resets when each request is accepted.
  - On reaching ACK_TIMEOUT: abort pulses for 1 cycle, both requests drop, state goes to IDLE, no retirement, and the architectural outputs keep the last retired values.
- Outputs hold their last values in IDLE.

Optional Feature:
Macro Z80_BLK_XFER_XY_FLAGS_EN.
- Defined: undocumented flags set from n = rdata + A (8-bit): F bit3 = n[3], F bit5 = n[1].
- Undefined: bits 3 and 5 are preserved from the input F.
- Both variants agree on every other field.

Test Plan:
- LDD, HL=0x1234, DE=0x5678, BC=0x0002, F=0xFF, read 0x5A -> write 0x5A @0x5678; HL=0x1233, DE=0x5677, BC=0x0001; F=0xED; IP+2; one z80fi_valid.
- LDI, BC=0x0001, F=0x00 -> BC=0x0000, PV=0, F=0x00; HL and DE +1; busy falls the cycle after RETIRE.
- LDIR, BC=0x0003, mem_ack held 1 -> three retirements spaced exactly 3 cycles apart; final IP=ip+2; intermediate ip_out=ip.
- LDDR, BC=0x0005, int_req=1 during the 2nd RETIRE -> stops after 2 iterations; BC=0x0003, PV=1, ip_out=ip.
- HL=0x0000 with LDD, BC=0x0000 -> HL=0xFFFF, BC=0xFFFF, PV=1; reset asserted during WRITE -> next cycle all outputs 0, state IDLE.
- ACK_TIMEOUT=4, no mem_ack -> abort pulses in the 4th READ cycle; no z80fi_valid; registers unchanged.

Source files
------------

// File: rtl/z80_blk_xfer_unit.sv
// Block-transfer execution unit (LDI/LDD/LDIR/LDDR): one read at HL, one write at DE, one retire per iteration.
// Optional macro Z80_BLK_XFER_XY_FLAGS_EN derives the undocumented F bits 3/5 from (byte + A).
module z80_blk_xfer_unit #(
   parameter int ACK_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] ip_in,
   input  logic [15:0] bc_in,
   input  logic [15:0] de_in,
   input  logic [15:0] hl_in,
   input  logic [7:0]  a_in,
   input  logic [7:0]  f_in,
   input  logic        int_req,
   output logic        busy,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [15:0] bc_out,
   output logic [15:0] de_out,
   output logic [15:0] hl_out,
   output logic [7:0]  f_out,
   output logic [15:0] ip_out,
   output logic        abort,
   output logic        z80fi_valid,
   output logic [15:0] z80fi_insn,
   output logic [15:0] z80fi_mem_raddr,
   output logic [15:0] z80fi_mem_waddr,
   output logic [7:0]  z80fi_mem_rdata,
   output logic [7:0]  z80fi_mem_wdata,
   output logic [15:0] z80fi_reg_bc_in,
   output logic [15:0] z80fi_reg_bc_out,
   output logic [15:0] z80fi_reg_de_in,
   output logic [15:0] z80fi_reg_de_out,
   output logic [15:0] z80fi_reg_hl_in,
   output logic [15:0] z80fi_reg_hl_out,
   output logic [15:0] z80fi_reg_ip_in,
   output logic [15:0] z80fi_reg_ip_out,
   output logic [7:0]  z80fi_reg_f_in,
   output logic [7:0]  z80fi_reg_f_out
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RETIRE} state_t;

   // Outputs are registered, so the abort decision is taken one cycle early:
   // abort is visible in the ACK_TIMEOUT-th cycle of a request (a setting of 1 behaves like 2).
   localparam logic [31:0] LIMIT = (ACK_TIMEOUT > 1) ? 32'(ACK_TIMEOUT - 2) : 32'd0;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] bc_q, bc_d, de_q, de_d, hl_q, hl_d, ip_q, ip_d;
   logic [7:0]  f_q, f_d, a_q, a_d, data_q, data_d;
   logic [31:0] cnt_q, cnt_d;

   logic        busy_q, busy_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic [15:0] bc_out_q, bc_out_d, de_out_q, de_out_d, hl_out_q, hl_out_d, ip_out_q, ip_out_d;
   logic [7:0]  f_out_q, f_out_d;
   logic        abort_q, abort_d, valid_q, valid_d;
   logic [15:0] insn_q, insn_d, raddr_q, raddr_d, waddr_q, waddr_d;
   logic [7:0]  fi_data_q, fi_data_d;
   logic [15:0] fi_bc_in_q, fi_bc_in_d, fi_de_in_q, fi_de_in_d;
   logic [15:0] fi_hl_in_q, fi_hl_in_d, fi_ip_in_q, fi_ip_in_d;
   logic [7:0]  fi_f_in_q, fi_f_in_d;

   logic        rd_ack, wr_ack, timeout, pv_p;
   logic [15:0] bc_p, de_p, hl_p, ip_p;
   logic [7:0]  f_p;
   logic        unused_bits;

`ifdef Z80_BLK_XFER_XY_FLAGS_EN
   logic [7:0] xy_sum;
   assign xy_sum      = data_q + a_q;
   assign f_p         = {f_q[7:6], xy_sum[1], 1'b0, xy_sum[3], pv_p, 1'b0, f_q[0]};
   assign unused_bits = ^{xy_sum[7:4], xy_sum[2], xy_sum[0], f_q[5:1]};
`else
   assign f_p         = {f_q[7:6], f_q[5], 1'b0, f_q[3], pv_p, 1'b0, f_q[0]};
   assign unused_bits = ^{a_q, f_q[4], f_q[2], f_q[1]};
`endif

   assign rd_ack  = mem_rd_q & mem_ack;
   assign wr_ack  = mem_wr_q & mem_ack;
   assign timeout = (ACK_TIMEOUT != 0) && (cnt_q == LIMIT);
   assign bc_p    = bc_q - 16'd1;
   assign hl_p    = op_q[0] ? hl_q - 16'd1 : hl_q + 16'd1;
   assign de_p    = op_q[0] ? de_q - 16'd1 : de_q + 16'd1;
   assign pv_p    = (bc_p != 16'd0);
   assign ip_p    = (op_q[1] && pv_p) ? ip_q : ip_q + 16'd2;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      bc_d       = bc_q;
      de_d       = de_q;
      hl_d       = hl_q;
      ip_d       = ip_q;
      f_d        = f_q;
      a_d        = a_q;
      data_d     = data_q;
      cnt_d      = 32'd0;
      bc_out_d   = bc_out_q;
      de_out_d   = de_out_q;
      hl_out_d   = hl_out_q;
      ip_out_d   = ip_out_q;
      f_out_d    = f_out_q;
      abort_d    = 1'b0;
      valid_d    = 1'b0;
      insn_d     = insn_q;
      raddr_d    = raddr_q;
      waddr_d    = waddr_q;
      fi_data_d  = fi_data_q;
      fi_bc_in_d = fi_bc_in_q;
      fi_de_in_d = fi_de_in_q;
      fi_hl_in_d = fi_hl_in_q;
      fi_ip_in_d = fi_ip_in_q;
      fi_f_in_d  = fi_f_in_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op;
               ip_d    = ip_in;
               bc_d    = bc_in;
               de_d    = de_in;
               hl_d    = hl_in;
               f_d     = f_in;
               a_d     = a_in;
               state_d = READ;
            end
         end
         READ: begin
            if (rd_ack) begin
               data_d  = mem_rdata;
               state_d = WRITE;
            end else if (timeout) begin
               abort_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         WRITE: begin
            if (wr_ack) begin
               // Publish the retirement record together with the new architectural state.
               valid_d    = 1'b1;
               insn_d     = {3'b101, op_q, 3'b000, 8'hED};
               raddr_d    = hl_q;
               waddr_d    = de_q;
               fi_data_d  = data_q;
               fi_bc_in_d = bc_q;
               fi_de_in_d = de_q;
               fi_hl_in_d = hl_q;
               fi_ip_in_d = ip_q;
               fi_f_in_d  = f_q;
               bc_out_d   = bc_p;
               de_out_d   = de_p;
               hl_out_d   = hl_p;
               ip_out_d   = ip_p;
               f_out_d    = f_p;
               bc_d       = bc_p;
               de_d       = de_p;
               hl_d       = hl_p;
               f_d        = f_p;
               state_d    = RETIRE;
            end else if (timeout) begin
               abort_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RETIRE: begin
            // Working registers already hold the primed values here.
            if (op_q[1] && (bc_q != 16'd0) && !int_req) state_d = READ;
            else                                      state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d      = (state_d != IDLE);
      mem_rd_d    = (state_d == READ);
      mem_wr_d    = (state_d == WRITE);
      mem_addr_d  = (state_d == READ) ? hl_d : (state_d == WRITE) ? de_d : mem_addr_q;
      mem_wdata_d = (state_d == WRITE) ? data_d : mem_wdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         op_q        <= 2'd0;
         bc_q        <= 16'd0;
         de_q        <= 16'd0;
         hl_q        <= 16'd0;
         ip_q        <= 16'd0;
         f_q         <= 8'd0;
         a_q         <= 8'd0;
         data_q      <= 8'd0;
         cnt_q       <= 32'd0;
         busy_q      <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= 16'd0;
         mem_wdata_q <= 8'd0;
         bc_out_q    <= 16'd0;
         de_out_q    <= 16'd0;
         hl_out_q    <= 16'd0;
         ip_out_q    <= 16'd0;
         f_out_q     <= 8'd0;
         abort_q     <= 1'b0;
         valid_q     <= 1'b0;
         insn_q      <= 16'd0;
         raddr_q     <= 16'd0;
         waddr_q     <= 16'd0;
         fi_data_q   <= 8'd0;
         fi_bc_in_q  <= 16'd0;
         fi_de_in_q  <= 16'd0;
         fi_hl_in_q  <= 16'd0;
         fi_ip_in_q  <= 16'd0;
         fi_f_in_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         bc_q        <= bc_d;
         de_q        <= de_d;
         hl_q        <= hl_d;
         ip_q        <= ip_d;
         f_q         <= f_d;
         a_q         <= a_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         bc_out_q    <= bc_out_d;
         de_out_q    <= de_out_d;
         hl_out_q    <= hl_out_d;
         ip_out_q    <= ip_out_d;
         f_out_q     <= f_out_d;
         abort_q     <= abort_d;
         valid_q     <= valid_d;
         insn_q      <= insn_d;
         raddr_q     <= raddr_d;
         waddr_q     <= waddr_d;
         fi_data_q   <= fi_data_d;
         fi_bc_in_q  <= fi_bc_in_d;
         fi_de_in_q  <= fi_de_in_d;
         fi_hl_in_q  <= fi_hl_in_d;
         fi_ip_in_q  <= fi_ip_in_d;
         fi_f_in_q   <= fi_f_in_d;
      end
   end

   assign busy             = busy_q;
   assign mem_rd           = mem_rd_q;
   assign mem_wr           = mem_wr_q;
   assign mem_addr         = mem_addr_q;
   assign mem_wdata        = mem_wdata_q;
   assign bc_out           = bc_out_q;
   assign de_out           = de_out_q;
   assign hl_out           = hl_out_q;
   assign f_out            = f_out_q;
   assign ip_out           = ip_out_q;
   assign abort            = abort_q;
   assign z80fi_valid      = valid_q;
   assign z80fi_insn       = insn_q;
   assign z80fi_mem_raddr  = raddr_q;
   assign z80fi_mem_waddr  = waddr_q;
   assign z80fi_mem_rdata  = fi_data_q;
   assign z80fi_mem_wdata  = fi_data_q;
   assign z80fi_reg_bc_in  = fi_bc_in_q;
   assign z80fi_reg_bc_out = bc_out_q;
   assign z80fi_reg_de_in  = fi_de_in_q;
   assign z80fi_reg_de_out = de_out_q;
   assign z80fi_reg_hl_in  = fi_hl_in_q;
   assign z80fi_reg_hl_out = hl_out_q;
   assign z80fi_reg_ip_in  = fi_ip_in_q;
   assign z80fi_reg_ip_out = ip_out_q;
   assign z80fi_reg_f_in   = fi_f_in_q;
   assign z80fi_reg_f_out  = f_out_q;

endmodule

// File: tb/tb_z80_blk_xfer_unit.sv
// Directed bench for z80_blk_xfer_unit (ACK_TIMEOUT=4): hand-computed expectations, sampled on negedge.
module tb_z80_blk_xfer_unit;

   logic        clk = 1'b0;
   logic        reset, start, int_req, mem_ack;
   logic [1:0]  op;
   logic [15:0] ip_in, bc_in, de_in, hl_in;
   logic [7:0]  a_in, f_in, mem_rdata;
   logic        busy, mem_rd, mem_wr, abort, z80fi_valid;
   logic [15:0] mem_addr, bc_out, de_out, hl_out, ip_out, z80fi_insn;
   logic [7:0]  mem_wdata, f_out, z80fi_mem_rdata, z80fi_mem_wdata;
   logic [15:0] z80fi_mem_raddr, z80fi_mem_waddr;
   logic [15:0] fi_bc_i, fi_bc_o, fi_de_i, fi_de_o, fi_hl_i, fi_hl_o, fi_ip_i, fi_ip_o;
   logic [7:0]  fi_f_i, fi_f_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   z80_blk_xfer_unit #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .ip_in(ip_in),
      .bc_in(bc_in), .de_in(de_in), .hl_in(hl_in), .a_in(a_in), .f_in(f_in),
      .int_req(int_req), .busy(busy), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .bc_out(bc_out), .de_out(de_out), .hl_out(hl_out), .f_out(f_out), .ip_out(ip_out),
      .abort(abort), .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn),
      .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_waddr(z80fi_mem_waddr),
      .z80fi_mem_rdata(z80fi_mem_rdata), .z80fi_mem_wdata(z80fi_mem_wdata),
      .z80fi_reg_bc_in(fi_bc_i), .z80fi_reg_bc_out(fi_bc_o),
      .z80fi_reg_de_in(fi_de_i), .z80fi_reg_de_out(fi_de_o),
      .z80fi_reg_hl_in(fi_hl_i), .z80fi_reg_hl_out(fi_hl_o),
      .z80fi_reg_ip_in(fi_ip_i), .z80fi_reg_ip_out(fi_ip_o),
      .z80fi_reg_f_in(fi_f_i), .z80fi_reg_f_out(fi_f_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %-22s got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %-22s value=%h", tag, got);
      end
   endtask

   // Presents start for one cycle; returns at the negedge of the first READ cycle.
   task automatic start_op(input logic [1:0] o, input logic [15:0] ip, input logic [15:0] bc,
                           input logic [15:0] de, input logic [15:0] hl, input logic [7:0] f);
      @(negedge clk);
      op = o; ip_in = ip; bc_in = bc; de_in = de; hl_in = hl; f_in = f; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (z80fi_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 32'(z80fi_valid), 32'd1);
   endtask

   int vcnt;
   int vcyc[3];
   logic [15:0] vip[3];
   logic seen_valid;

   initial begin
      reset = 1'b1; start = 1'b0; int_req = 1'b0; mem_ack = 1'b0; op = 2'b00;
      ip_in = 16'h0; bc_in = 16'h0; de_in = 16'h0; hl_in = 16'h0; a_in = 8'h00; f_in = 8'h00;
      mem_rdata = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("reset busy", 32'(busy), 32'd0);
      check_eq("reset mem_rd", 32'(mem_rd), 32'd0);
      check_eq("reset valid", 32'(z80fi_valid), 32'd0);
      check_eq("reset bc_out", 32'(bc_out), 32'd0);

      // LDD single iteration
      mem_ack = 1'b1; mem_rdata = 8'h5A;
      start_op(2'b01, 16'h0100, 16'h0002, 16'h5678, 16'h1234, 8'hFF);
      check_eq("ldd busy", 32'(busy), 32'd1);
      check_eq("ldd mem_rd", 32'(mem_rd), 32'd1);
      check_eq("ldd rd addr", 32'(mem_addr), 32'h1234);
      @(negedge clk);
      check_eq("ldd mem_wr", 32'(mem_wr), 32'd1);
      check_eq("ldd mem_rd low", 32'(mem_rd), 32'd0);
      check_eq("ldd wr addr", 32'(mem_addr), 32'h5678);
      check_eq("ldd wdata", 32'(mem_wdata), 32'h5A);
      @(negedge clk);
      check_eq("ldd valid", 32'(z80fi_valid), 32'd1);
      check_eq("ldd insn", 32'(z80fi_insn), 32'hA8ED);
      check_eq("ldd hl", 32'(hl_out), 32'h1233);
      check_eq("ldd de", 32'(de_out), 32'h5677);
      check_eq("ldd bc", 32'(bc_out), 32'h0001);
      check_eq("ldd f", 32'(f_out), 32'hED);
      check_eq("ldd ip", 32'(ip_out), 32'h0102);
      check_eq("ldd fi raddr", 32'(z80fi_mem_raddr), 32'h1234);
      check_eq("ldd fi waddr", 32'(z80fi_mem_waddr), 32'h5678);
      check_eq("ldd fi rdata", 32'(z80fi_mem_rdata), 32'h5A);
      check_eq("ldd fi wdata", 32'(z80fi_mem_wdata), 32'h5A);
      check_eq("ldd fi bc_in", 32'(fi_bc_i), 32'h0002);
      check_eq("ldd fi f_in", 32'(fi_f_i), 32'hFF);
      check_eq("ldd fi ip_in", 32'(fi_ip_i), 32'h0100);
      @(negedge clk);
      check_eq("ldd valid pulse", 32'(z80fi_valid), 32'd0);
      check_eq("ldd busy fall", 32'(busy), 32'd0);

      // LDI with BC=1: PV clears, busy falls after RETIRE
      mem_rdata = 8'h00;
      start_op(2'b00, 16'h0110, 16'h0001, 16'h3000, 16'h2000, 8'h00);
      wait_valid("ldi valid");
      check_eq("ldi insn", 32'(z80fi_insn), 32'hA0ED);
      check_eq("ldi bc", 32'(bc_out), 32'h0000);
      check_eq("ldi f", 32'(f_out), 32'h00);
      check_eq("ldi hl", 32'(hl_out), 32'h2001);
      check_eq("ldi de", 32'(de_out), 32'h3001);
      check_eq("ldi ip", 32'(ip_out), 32'h0112);
      check_eq("ldi busy in retire", 32'(busy), 32'd1);
      @(negedge clk);
      check_eq("ldi busy fall", 32'(busy), 32'd0);

      // LDIR BC=3, ack held; stray start mid-run must be ignored
      mem_rdata = 8'h11; vcnt = 0; vcyc = '{0, 0, 0}; vip = '{16'h0, 16'h0, 16'h0};
      start_op(2'b10, 16'h0200, 16'h0003, 16'h5000, 16'h4000, 8'h00);
      for (int i = 0; i < 20; i++) begin
         if (z80fi_valid === 1'b1) begin
            if (vcnt < 3) begin
               vcyc[vcnt] = cyc;
               vip[vcnt] = ip_out;
            end
            vcnt++;
         end
         start = (i == 4);
         op = 2'b01;
         @(negedge clk);
      end
      start = 1'b0;
      check_eq("ldir retire count", 32'(vcnt), 32'd3);
      check_eq("ldir spacing 1", 32'(vcyc[1] - vcyc[0]), 32'd3);
      check_eq("ldir spacing 2", 32'(vcyc[2] - vcyc[1]), 32'd3);
      check_eq("ldir ip iter1", 32'(vip[0]), 32'h0200);
      check_eq("ldir ip iter2", 32'(vip[1]), 32'h0200);
      check_eq("ldir ip final", 32'(vip[2]), 32'h0202);
      check_eq("ldir bc", 32'(bc_out), 32'h0000);
      check_eq("ldir hl", 32'(hl_out), 32'h4003);
      check_eq("ldir de", 32'(de_out), 32'h5003);
      check_eq("ldir f", 32'(f_out), 32'h00);

      // LDDR BC=5, interrupt during second RETIRE
      mem_rdata = 8'h22; vcnt = 0;
      start_op(2'b11, 16'h0300, 16'h0005, 16'h7000, 16'h6000, 8'h00);
      for (int i = 0; i < 20; i++) begin
         if (z80fi_valid === 1'b1) begin
            vcnt++;
            if (vcnt == 2) int_req = 1'b1;
         end
         @(negedge clk);
      end
      int_req = 1'b0;
      check_eq("lddr retire count", 32'(vcnt), 32'd2);
      check_eq("lddr bc", 32'(bc_out), 32'h0003);
      check_eq("lddr f pv", 32'(f_out), 32'h04);
      check_eq("lddr ip", 32'(ip_out), 32'h0300);
      check_eq("lddr hl", 32'(hl_out), 32'h5FFE);
      check_eq("lddr de", 32'(de_out), 32'h6FFE);
      check_eq("lddr busy", 32'(busy), 32'd0);

      // LDD wrap: HL=0, BC=0
      mem_rdata = 8'h33;
      start_op(2'b01, 16'h0400, 16'h0000, 16'h0010, 16'h0000, 8'h00);
      wait_valid("wrap valid");
      check_eq("wrap hl", 32'(hl_out), 32'hFFFF);
      check_eq("wrap bc", 32'(bc_out), 32'hFFFF);
      check_eq("wrap de", 32'(de_out), 32'h000F);
      check_eq("wrap f pv", 32'(f_out), 32'h04);
      check_eq("wrap ip", 32'(ip_out), 32'h0402);
      @(negedge clk);

      // Ack timeout: abort in the 4th READ cycle
      mem_ack = 1'b0; seen_valid = 1'b0;
      start_op(2'b00, 16'h0500, 16'h0007, 16'h9000, 16'h8000, 8'h00);
      for (int i = 1; i <= 3; i++) begin
         check_eq($sformatf("to abort c%0d", i), 32'(abort), 32'd0);
         check_eq($sformatf("to mem_rd c%0d", i), 32'(mem_rd), 32'd1);
         seen_valid |= z80fi_valid;
         @(negedge clk);
      end
      check_eq("to abort c4", 32'(abort), 32'd1);
      check_eq("to mem_rd drop", 32'(mem_rd), 32'd0);
      seen_valid |= z80fi_valid;
      @(negedge clk);
      seen_valid |= z80fi_valid;
      check_eq("to abort pulse", 32'(abort), 32'd0);
      check_eq("to busy", 32'(busy), 32'd0);
      check_eq("to no retire", 32'(seen_valid), 32'd0);
      check_eq("to bc kept", 32'(bc_out), 32'hFFFF);
      check_eq("to hl kept", 32'(hl_out), 32'hFFFF);

      // Reset during WRITE
      mem_ack = 1'b1;
      start_op(2'b00, 16'h0600, 16'h0010, 16'hA000, 16'h9000, 8'hC1);
      @(negedge clk);
      check_eq("rst in write", 32'(mem_wr), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst mem_wr", 32'(mem_wr), 32'd0);
      check_eq("rst mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst bc_out", 32'(bc_out), 32'd0);
      check_eq("rst ip_out", 32'(ip_out), 32'd0);
      check_eq("rst valid", 32'(z80fi_valid), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst stays idle", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
